sram_req_arbiter: RTL and testbench

- Shares one like-SRAM master port (the data-side port of the AXI bridge) between NREQ like-SRAM requesters, e.g. the uncached load/store unit and the cache refill/writeback engines.
- Arbitrates round-robin and locks the grant until the address handshake completes.
- Records each accepted grant in an in-order tag FIFO so that every downstream data_ok and rdata is routed back to the requester that issued it.
- Sits between the CPU-side memory clients and the bridge.

---
 rtl/sram_arb_pkg.sv | 18 +
 rtl/tag_fifo.sv | 50 +++++
 rtl/sram_req_arbiter.sv | 132 +++++++++++++
 tb/tb_sram_req_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared constants for the like-SRAM request arbiter: FSM encodings,
// transfer-size codes and the packed-slice widths of the requester buses.
package sram_arb_pkg;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // Per-requester slice widths inside the packed request buses.
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  localparam int SIZE_W = 2;

endpackage

// File: rtl/tag_fifo.sv
// In-order FIFO of requester tags; push and pop may occur in the same cycle,
// in which case the occupancy is unchanged and the pop returns the old head.
module tag_fifo import sram_arb_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int IDW   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [IDW-1:0]           push_data,
  input  logic                     pop,
  output logic [IDW-1:0]           head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [IDW-1:0] mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic           push_ok;
  logic           pop_ok;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Pointers are exactly PW bits wide so they wrap at DEPTH on their own.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + PW'(1);
      if (push_ok && !pop_ok)      count <= count + (PW+1)'(1);
      else if (pop_ok && !push_ok) count <= count - (PW+1)'(1);
    end
  end

endmodule

// File: rtl/sram_req_arbiter.sv
// Round-robin arbiter sharing one like-SRAM master port between NREQ requesters;
// accepted grants are queued as tags so in-order responses route back correctly.
module sram_req_arbiter import sram_arb_pkg::*; #(
  parameter int NREQ  = 2,
  parameter int DEPTH = 4,
  parameter int IDW   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          req_wr,
  input  logic [SIZE_W*NREQ-1:0]   req_size,
  input  logic [STRB_W*NREQ-1:0]   req_wstrb,
  input  logic [ADDR_W*NREQ-1:0]   req_addr,
  input  logic [DATA_W*NREQ-1:0]   req_wdata,
  output logic [NREQ-1:0]          req_addr_ok,
  output logic [NREQ-1:0]          req_data_ok,
  output logic [DATA_W-1:0]        req_rdata,
  output logic                     m_req,
  output logic                     m_wr,
  output logic [SIZE_W-1:0]        m_size,
  output logic [STRB_W-1:0]        m_wstrb,
  output logic [ADDR_W-1:0]        m_addr,
  output logic [DATA_W-1:0]        m_wdata,
  input  logic                     m_addr_ok,
  input  logic                     m_data_ok,
  input  logic [DATA_W-1:0]        m_rdata,
  output logic [$clog2(DEPTH):0]   outstanding,
  output logic                     err,
  output logic [0:0]               fsm_state
);

  // Handshake: a request is accepted exactly in the cycle where m_req and
  // m_addr_ok are both high; a response is m_data_ok alone (no back-pressure).
  logic [0:0]     state;
  logic [IDW-1:0] grant;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] pick;
  logic           pick_valid;
  logic           accept;
  logic           pop;
  logic [IDW-1:0] head;
  logic           full;
  logic           empty;

  assign fsm_state = state;
  assign req_rdata = m_rdata;
  assign accept    = m_req & m_addr_ok;
  assign pop       = m_data_ok & ~empty;

  // Lowest offset from rr_ptr wins: scan offsets high-to-low so the last hit sticks.
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      for (int j = 0; j < NREQ; j++) begin
        if (req[j] && (j == ((int'(rr_ptr) + k) % NREQ))) begin
          pick       = IDW'(j);
          pick_valid = 1'b1;
        end
      end
    end
  end

  // Master payload is a straight mux of the granted slice; zero outside GRANT.
  always_comb begin
    m_req       = 1'b0;
    m_wr        = 1'b0;
    m_size      = '0;
    m_wstrb     = '0;
    m_addr      = '0;
    m_wdata     = '0;
    req_data_ok = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (state == GRANT && grant == IDW'(j)) begin
        m_req   = req[j];
        m_wr    = req_wr[j];
        m_size  = req_size[j*SIZE_W +: SIZE_W];
        m_wstrb = req_wstrb[j*STRB_W +: STRB_W];
        m_addr  = req_addr[j*ADDR_W +: ADDR_W];
        m_wdata = req_wdata[j*DATA_W +: DATA_W];
      end
      req_data_ok[j] = pop && (head == IDW'(j));
    end
  end

  always_comb begin
    req_addr_ok = '0;
    for (int j = 0; j < NREQ; j++) req_addr_ok[j] = accept && (grant == IDW'(j));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
      err    <= 1'b0;
    end else begin
      if (m_data_ok && empty) err <= 1'b1;
      if (state == IDLE) begin
        // full is registered, so a pop this cycle only unblocks next cycle.
        if (pick_valid && !full) begin
          grant <= pick;
          state <= GRANT;
        end
      end else begin
        if (accept) begin
          rr_ptr <= (grant == IDW'(NREQ - 1)) ? '0 : grant + IDW'(1);
          state  <= IDLE;
        end else if (!m_req) begin
          state <= IDLE;
        end
      end
    end
  end

  tag_fifo #(
    .DEPTH (DEPTH),
    .IDW   (IDW)
  ) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (accept),
    .push_data (grant),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (outstanding)
  );

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter (NREQ=2, DEPTH=4): inputs change just
// after the falling edge and outputs are checked 1 ns later.
module tb_sram_req_arbiter;
  import sram_arb_pkg::*;

  logic        clk;
  logic        reset;
  logic [1:0]  req;
  logic [1:0]  req_wr;
  logic [3:0]  req_size;
  logic [7:0]  req_wstrb;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  req_addr_ok;
  logic [1:0]  req_data_ok;
  logic [31:0] req_rdata;
  logic        m_req;
  logic        m_wr;
  logic [1:0]  m_size;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_addr_ok;
  logic        m_data_ok;
  logic [31:0] m_rdata;
  logic [2:0]  outstanding;
  logic        err;
  logic [0:0]  fsm_state;

  int vectors;
  int miscompares;

  sram_req_arbiter #(.NREQ(2), .DEPTH(4), .IDW(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_wr      (req_wr),
    .req_size    (req_size),
    .req_wstrb   (req_wstrb),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_addr_ok (req_addr_ok),
    .req_data_ok (req_data_ok),
    .req_rdata   (req_rdata),
    .m_req       (m_req),
    .m_wr        (m_wr),
    .m_size      (m_size),
    .m_wstrb     (m_wstrb),
    .m_addr      (m_addr),
    .m_wdata     (m_wdata),
    .m_addr_ok   (m_addr_ok),
    .m_data_ok   (m_data_ok),
    .m_rdata     (m_rdata),
    .outstanding (outstanding),
    .err         (err),
    .fsm_state   (fsm_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of sequence, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    req         = '0;
    req_wr      = '0;
    req_size    = '0;
    req_wstrb   = '0;
    req_addr    = '0;
    req_wdata   = '0;
    m_addr_ok   = 1'b0;
    m_data_ok   = 1'b0;
    m_rdata     = '0;

    // Reset state
    @(negedge clk); #1;
    chk("rst_m_req", 32'(m_req), 32'h0);
    chk("rst_m_addr", m_addr, 32'h0);
    chk("rst_addr_ok", 32'(req_addr_ok), 32'h0);
    chk("rst_data_ok", 32'(req_data_ok), 32'h0);
    chk("rst_outstanding", 32'(outstanding), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_state", 32'(fsm_state), 32'h0);
    @(negedge clk); reset = 1'b0;

    // Single read from requester 0
    @(negedge clk);
    req = 2'b01; req_addr[31:0] = 32'h1c00_0000; req_size[1:0] = SZ_W;
    #1;
    chk("rd_bubble_m_req", 32'(m_req), 32'h0);
    @(negedge clk);
    m_addr_ok = 1'b1;
    #1;
    chk("rd_m_req", 32'(m_req), 32'h1);
    chk("rd_m_addr", m_addr, 32'h1c00_0000);
    chk("rd_m_size", 32'(m_size), 32'h2);
    chk("rd_m_wr", 32'(m_wr), 32'h0);
    chk("rd_addr_ok", 32'(req_addr_ok), 32'h1);
    chk("rd_state", 32'(fsm_state), 32'h1);
    @(negedge clk);
    req = 2'b00; m_addr_ok = 1'b0; m_data_ok = 1'b1; m_rdata = 32'hdead_beef;
    #1;
    chk("rd_outstanding1", 32'(outstanding), 32'h1);
    chk("rd_m_req_idle", 32'(m_req), 32'h0);
    chk("rd_data_ok", 32'(req_data_ok), 32'h1);
    chk("rd_rdata", req_rdata, 32'hdead_beef);
    @(negedge clk);
    m_data_ok = 1'b0;
    #1;
    chk("rd_outstanding0", 32'(outstanding), 32'h0);
    chk("rd_data_ok_clr", 32'(req_data_ok), 32'h0);

    // Contention: rr_ptr is now 1, so grants go 1,0,1,0
    req_addr  = {32'h2000_0010, 32'h1000_0020};
    req_wr    = 2'b10;
    req_wstrb = 8'hF0;
    req_wdata = {32'hcafe_f00d, 32'h0000_0000};
    req_size  = {SZ_W, SZ_H};
    @(negedge clk);
    req = 2'b11; m_addr_ok = 1'b1;
    #1;
    chk("ct_bubble0", 32'(m_req), 32'h0);
    @(negedge clk); #1;
    chk("ct_addr_ok_g1", 32'(req_addr_ok), 32'h2);
    chk("ct_m_addr_g1", m_addr, 32'h2000_0010);
    chk("ct_m_wr_g1", 32'(m_wr), 32'h1);
    chk("ct_m_wdata_g1", m_wdata, 32'hcafe_f00d);
    chk("ct_m_wstrb_g1", 32'(m_wstrb), 32'hf);
    @(negedge clk); #1;
    chk("ct_bubble1", 32'(m_req), 32'h0);
    chk("ct_outstanding1", 32'(outstanding), 32'h1);
    @(negedge clk); #1;
    chk("ct_addr_ok_g0", 32'(req_addr_ok), 32'h1);
    chk("ct_m_addr_g0", m_addr, 32'h1000_0020);
    chk("ct_m_size_g0", 32'(m_size), 32'h1);
    chk("ct_m_wr_g0", 32'(m_wr), 32'h0);
    @(negedge clk);
    @(negedge clk); #1;
    chk("ct_addr_ok_g1b", 32'(req_addr_ok), 32'h2);
    @(negedge clk);
    @(negedge clk); #1;
    chk("ct_addr_ok_g0b", 32'(req_addr_ok), 32'h1);

    // Backpressure: FIFO now holds 1,0,1,0 and is full
    @(negedge clk);
    m_addr_ok = 1'b0;
    #1;
    chk("bp_outstanding4", 32'(outstanding), 32'h4);
    chk("bp_m_req0", 32'(m_req), 32'h0);
    @(negedge clk); #1;
    chk("bp_m_req_held", 32'(m_req), 32'h0);
    chk("bp_state_idle", 32'(fsm_state), 32'h0);
    m_data_ok = 1'b1;
    #1;
    chk("bp_data_ok_head1", 32'(req_data_ok), 32'h2);
    @(negedge clk);
    m_data_ok = 1'b0;
    #1;
    chk("bp_outstanding3", 32'(outstanding), 32'h3);
    chk("bp_no_same_cycle_grant", 32'(fsm_state), 32'h0);
    @(negedge clk); #1;
    chk("bp_regrant_m_req", 32'(m_req), 32'h1);
    chk("bp_regrant_addr", m_addr, 32'h2000_0010);

    // Cancel: requester 1 drops its request while granted
    req = 2'b01; m_addr_ok = 1'b1;
    #1;
    chk("cx_m_req", 32'(m_req), 32'h0);
    chk("cx_addr_ok", 32'(req_addr_ok), 32'h0);
    @(negedge clk);
    m_addr_ok = 1'b0;
    #1;
    chk("cx_outstanding", 32'(outstanding), 32'h3);
    chk("cx_state_idle", 32'(fsm_state), 32'h0);
    @(negedge clk); #1;
    chk("cx_next_m_req", 32'(m_req), 32'h1);
    chk("cx_next_addr", m_addr, 32'h1000_0020);

    // Drain one (head 0) while still granted, then push and pop together at 2
    m_data_ok = 1'b1;
    #1;
    chk("pp_pre_data_ok", 32'(req_data_ok), 32'h1);
    @(negedge clk);
    m_data_ok = 1'b0;
    #1;
    chk("pp_outstanding2", 32'(outstanding), 32'h2);
    m_addr_ok = 1'b1; m_data_ok = 1'b1;
    #1;
    chk("pp_addr_ok", 32'(req_addr_ok), 32'h1);
    chk("pp_data_ok_old_head", 32'(req_data_ok), 32'h2);
    @(negedge clk);
    req = 2'b00; m_addr_ok = 1'b0; m_data_ok = 1'b0;
    #1;
    chk("pp_outstanding_same", 32'(outstanding), 32'h2);
    m_data_ok = 1'b1;
    #1;
    chk("pp_drain_a", 32'(req_data_ok), 32'h1);
    @(negedge clk); #1;
    chk("pp_drain_tail", 32'(req_data_ok), 32'h1);
    @(negedge clk);
    m_data_ok = 1'b0;
    #1;
    chk("pp_outstanding0", 32'(outstanding), 32'h0);

    // Response with empty FIFO sets the sticky error
    m_data_ok = 1'b1;
    #1;
    chk("er_no_data_ok", 32'(req_data_ok), 32'h0);
    chk("er_not_yet", 32'(err), 32'h0);
    @(negedge clk);
    m_data_ok = 1'b0;
    #1;
    chk("er_set", 32'(err), 32'h1);
    chk("er_outstanding", 32'(outstanding), 32'h0);

    // Three accepts from requester 0, then park in GRANT and reset
    req = 2'b01; m_addr_ok = 1'b1;
    repeat (6) @(negedge clk);
    m_addr_ok = 1'b0;
    @(negedge clk); #1;
    chk("mr_state_grant", 32'(fsm_state), 32'h1);
    chk("mr_m_req", 32'(m_req), 32'h1);
    chk("mr_outstanding3", 32'(outstanding), 32'h3);
    chk("mr_err_sticky", 32'(err), 32'h1);
    reset = 1'b1;
    #1;
    chk("mr_rst_m_req", 32'(m_req), 32'h0);
    chk("mr_rst_m_addr", m_addr, 32'h0);
    chk("mr_rst_outstanding", 32'(outstanding), 32'h0);
    chk("mr_rst_err", 32'(err), 32'h0);
    chk("mr_rst_state", 32'(fsm_state), 32'h0);
    @(negedge clk);
    reset = 1'b0; req = 2'b00; m_data_ok = 1'b1;
    #1;
    chk("mr_stale_no_data_ok", 32'(req_data_ok), 32'h0);
    @(negedge clk);
    m_data_ok = 1'b0;
    #1;
    chk("mr_stale_err", 32'(err), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
